// File: rtl/ram_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ram_port_arbiter_pkg
// Purpose  : Shared types and default widths for the RAM port arbiter.
//            Read-owner encoding tags which requester the word coming back
//            from the RAM belongs to.
// Ports    : none (package)
// Revision : 1.0  initial release
// ============================================================================
package ram_port_arbiter_pkg;

  // Default widths, mirroring the core's common width constants.
  localparam int unsigned DEF_ADDR_WIDTH   = 8;
  localparam int unsigned DEF_WORD_WIDTH   = 8;
  localparam int unsigned DEF_STARVE_LIMIT = 4;
  localparam int unsigned DEF_CNT_WIDTH    = 3;

  // Owner of the read launched on the previous edge.
  typedef enum logic [1:0] {
    RD_NONE = 2'd0,
    RD_IF   = 2'd1,
    RD_LS   = 2'd2
  } rd_owner_e;

endpackage
`default_nettype wire

// File: rtl/ram_starve_counter.sv
`default_nettype none
// ============================================================================
// Module   : ram_starve_counter
// Purpose  : Saturating count of consecutive cycles in which the instruction
//            fetch requester asked for the read port and was denied.
//            at_limit tells the arbiter to let fetch win the next conflict.
// Ports    : clk      - clock, state on rising edge
//            rst_n    - asynchronous active-low reset
//            req      - fetch requesting this cycle
//            gnt      - fetch granted this cycle
//            at_limit - counter equals STARVE_LIMIT
// Revision : 1.0  initial release
// ============================================================================
module ram_starve_counter
  import ram_port_arbiter_pkg::*;
#(
  parameter int unsigned CNT_WIDTH    = DEF_CNT_WIDTH,
  parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req,
  input  logic gnt,
  output logic at_limit
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] LIMIT   = CNT_WIDTH'(STARVE_LIMIT);
  localparam logic [CNT_WIDTH-1:0] ONE     = CNT_WIDTH'(1);

  logic [CNT_WIDTH-1:0] r_cnt;

  // A grant always clears; a denied request counts up but never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (gnt) begin
      r_cnt <= '0;
    end else if (req && (r_cnt != CNT_MAX)) begin
      r_cnt <= r_cnt + ONE;
    end
  end

  assign at_limit = (r_cnt == LIMIT);

endmodule
`default_nettype wire

// File: rtl/ram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ram_port_arbiter
// Purpose  : Shares one synchronous RAM (1-cycle registered read port plus an
//            independent write port) between instruction fetch (IF, reads
//            only) and load/store (LS, read or write). LS writes are always
//            granted; read conflicts go to LS unless IF has been starved for
//            STARVE_LIMIT cycles. The owner of each read is tracked so the
//            returned word is qualified to the right requester.
// Config   : `define RAM_WRITE_BYPASS_EN forwards write data to a read of the
//            same address granted in the same cycle (otherwise the RAM's
//            read-before-write data is returned).
// Ports    : gclk, nreset                  - clock, async active-low reset
//            IfReq/IfAddr/IfGnt             - fetch request side
//            IfRvalid/IfRdata               - fetch response side
//            LsReq/LsWe/LsAddr/LsWdata/LsGnt - load/store request side
//            LsRvalid/LsRdata               - load/store response side
//            RamWriteEnable/RamWriteAddr/RamWriteData - RAM write port
//            RamReadAddr/RamReadData        - RAM read port
// Revision : 1.0  initial release
// ============================================================================
module ram_port_arbiter
  import ram_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int unsigned WORD_WIDTH   = DEF_WORD_WIDTH,
  parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT,
  parameter int unsigned CNT_WIDTH    = DEF_CNT_WIDTH
) (
  input  logic                  gclk,
  input  logic                  nreset,
  input  logic                  IfReq,
  input  logic [ADDR_WIDTH-1:0] IfAddr,
  output logic                  IfGnt,
  output logic                  IfRvalid,
  output logic [WORD_WIDTH-1:0] IfRdata,
  input  logic                  LsReq,
  input  logic                  LsWe,
  input  logic [ADDR_WIDTH-1:0] LsAddr,
  input  logic [WORD_WIDTH-1:0] LsWdata,
  output logic                  LsGnt,
  output logic                  LsRvalid,
  output logic [WORD_WIDTH-1:0] LsRdata,
  output logic                  RamWriteEnable,
  output logic [ADDR_WIDTH-1:0] RamReadAddr,
  output logic [ADDR_WIDTH-1:0] RamWriteAddr,
  output logic [WORD_WIDTH-1:0] RamWriteData,
  input  logic [WORD_WIDTH-1:0] RamReadData
);

  logic                  w_ls_rd;
  logic                  w_ls_wr;
  logic                  w_at_limit;
  logic                  w_if_gnt;
  logic                  w_ls_rd_gnt;
  logic                  w_wr_gnt;
  logic [ADDR_WIDTH-1:0] w_rd_addr;
  rd_owner_e             w_owner_nxt;
  rd_owner_e             r_owner;
  logic [WORD_WIDTH-1:0] w_rd_data;

  assign w_ls_rd = LsReq & ~LsWe;
  assign w_ls_wr = LsReq &  LsWe;

  ram_starve_counter #(
    .CNT_WIDTH    (CNT_WIDTH),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_starve_counter (
    .clk      (gclk),
    .rst_n    (nreset),
    .req      (IfReq),
    .gnt      (w_if_gnt),
    .at_limit (w_at_limit)
  );

  // Read-port arbitration. Grants are forced low while reset is asserted so
  // nothing is launched into the RAM during reset.
  always_comb begin
    w_if_gnt    = 1'b0;
    w_ls_rd_gnt = 1'b0;
    w_wr_gnt    = 1'b0;
    w_owner_nxt = RD_NONE;
    w_rd_addr   = '0;
    if (nreset) begin
      w_wr_gnt = w_ls_wr;
      if (IfReq && w_ls_rd) begin
        if (w_at_limit) begin
          w_if_gnt = 1'b1;
        end else begin
          w_ls_rd_gnt = 1'b1;
        end
      end else begin
        w_if_gnt    = IfReq;
        w_ls_rd_gnt = w_ls_rd;
      end
    end
    if (w_if_gnt) begin
      w_owner_nxt = RD_IF;
      w_rd_addr   = IfAddr;
    end else if (w_ls_rd_gnt) begin
      w_owner_nxt = RD_LS;
      w_rd_addr   = LsAddr;
    end
  end

  assign IfGnt          = w_if_gnt;
  assign LsGnt          = w_ls_rd_gnt | w_wr_gnt;
  assign RamReadAddr    = w_rd_addr;
  assign RamWriteEnable = w_wr_gnt;
  assign RamWriteAddr   = w_wr_gnt ? LsAddr  : '0;
  assign RamWriteData   = w_wr_gnt ? LsWdata : '0;

  // The owner register lines up with the RAM's one-cycle read latency.
  always_ff @(posedge gclk or negedge nreset) begin
    if (!nreset) begin
      r_owner <= RD_NONE;
    end else begin
      r_owner <= w_owner_nxt;
    end
  end

`ifdef RAM_WRITE_BYPASS_EN
  logic                  r_fwd_hit;
  logic [WORD_WIDTH-1:0] r_fwd_data;

  // The RAM reads before it writes, so a same-cycle collision would return
  // stale data; capture the write data and substitute it on the response.
  always_ff @(posedge gclk or negedge nreset) begin
    if (!nreset) begin
      r_fwd_hit  <= 1'b0;
      r_fwd_data <= '0;
    end else begin
      r_fwd_hit  <= w_wr_gnt & (w_if_gnt | w_ls_rd_gnt) & (LsAddr == w_rd_addr);
      r_fwd_data <= RamWriteData;
    end
  end

  assign w_rd_data = r_fwd_hit ? r_fwd_data : RamReadData;
`else
  assign w_rd_data = RamReadData;
`endif

  assign IfRvalid = (r_owner == RD_IF);
  assign LsRvalid = (r_owner == RD_LS);
  assign IfRdata  = w_rd_data;
  assign LsRdata  = w_rd_data;

endmodule
`default_nettype wire

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares the single synchronous RAM between two requesters: instruction fetch (IF, read-only) and load/store (LS, read or write).
- The RAM has one read port (1-cycle registered read) and one write port. An IF read and an LS write can therefore proceed in the same cycle. Only two simultaneous reads conflict.
- The block arbitrates the read port and carries a starvation guard for IF. It also tracks read ownership so each returned word is qualified to the correct requester.

Parameters:
- ADDR_WIDTH, 8, RAM address width.
- WORD_WIDTH, 8, RAM data width.
- STARVE_LIMIT, 4, consecutive denied IF cycles before IF is forced to win the next read conflict (range 1..2^CNT_WIDTH-1).
- CNT_WIDTH, 3, width of the starvation counter.

Ports:
- gclk  in  1  system clock, all state on posedge.
- nreset  in  1  asynchronous, active-low reset.
- IfReq  in  1  IF read request.
- IfAddr  in  ADDR_WIDTH  IF read address.
- IfGnt  out  1  IF request accepted this cycle (combinational).
- IfRvalid  out  1  IfRdata valid; registered.
- IfRdata  out  WORD_WIDTH  IF read data.
- LsReq  in  1  LS request.
- LsWe  in  1  1 = write, 0 = read.
- LsAddr  in  ADDR_WIDTH  LS address.
- LsWdata  in  WORD_WIDTH  LS write data.
- LsGnt  out  1  LS request accepted this cycle (combinational).
- LsRvalid  out  1  LsRdata valid; registered.
- LsRdata  out  WORD_WIDTH  LS read data.
- RamWriteEnable  out  1  to RAM.
- RamReadAddr  out  ADDR_WIDTH  to RAM.
- RamWriteAddr  out  ADDR_WIDTH  to RAM.
- RamWriteData  out  WORD_WIDTH  to RAM.
- RamReadData  in  WORD_WIDTH  from RAM, valid the cycle after the address is presented.

Behaviour:
- Reset (nreset low, asynchronous):
  - starve_cnt = 0; rd_owner = NONE.
  - IfRvalid = LsRvalid = 0.
  - Grants are 0 while nreset is low.
- LS write (LsReq & LsWe): always granted the same cycle.
  - RamWriteEnable = 1, RamWriteAddr = LsAddr, RamWriteData = LsWdata.
  - Otherwise RamWriteEnable = 0; write address and data are don't-care (drive 0).
- Read arbitration, per cycle, combinational from the requests and registered state:
  - Only IfReq: IF granted.
  - Only an LS read: LS granted.
  - Both reads: LS wins, unless starve_cnt == STARVE_LIMIT, in which case IF wins.
  - IF read together with an LS write: both granted.
- RamReadAddr = address of the granted reader; 0 when there is no read.
- starve_cnt:
  - Increments (saturating) on each cycle IfReq=1 and IfGnt=0.
  - Clears on any IfGnt=1 cycle.
  - Holds when IfReq=0.
- rd_owner register: set on each edge to IF, LS or NONE according to the read granted that cycle.
- Read response, one cycle after the grant:
  - IfRvalid = (rd_owner==IF); LsRvalid = (rd_owner==LS). Never both high.
  - IfRdata and LsRdata = RamReadData, or the forwarded value (see Optional Feature).
- Throughput: one read per cycle and, in parallel, one write per cycle. No bubbles on back-to-back grants.
- A denied requester keeps its request and address stable until granted. The block does not latch denied requests.
- Write then read of the same address on the next cycle returns the new data, because of the RAM's own timing.
- Same-cycle granted read and write to the same address: the RAM returns old data (read-before-write). See Optional Feature.
- Reset asserted mid-read: the pending rvalid is dropped and no data is delivered for that read.

Optional Feature:
- Macro RAM_WRITE_BYPASS_EN.
- Defined:
  - On each edge, register fwd_hit = (write granted & read granted & RamWriteAddr==RamReadAddr), together with the write data.
  - On the response cycle, if fwd_hit, the read data outputs carry the registered write data instead of RamReadData.
  - Both registers reset to 0.
- Undefined: no forwarding logic; read-before-write data is returned.

Decomposition:
- Shared package:
  - Read-owner encoding: NONE=2'd0, IF=2'd1, LS=2'd2.
  - Default widths, reused from the core's common width header constants.
- One sub-module is natural: ram_starve_counter, the saturating counter with its clear/increment/limit-compare.

Test Plan:
- Reset: hold nreset=0 with both requests active -> grants=0, rvalids=0. Release -> IfReq only, IfAddr=0x10 with mem[0x10]=0xA5 -> IfGnt=1 same cycle; next cycle IfRvalid=1, IfRdata=0xA5.
- Conflict: IfReq and LS read both held for 6 cycles (STARVE_LIMIT=4) -> LsGnt cycles 0-3, IfGnt cycle 4, LsGnt cycle 5; starve_cnt back to 0 after cycle 4.
- Concurrency: IF read 0x20 plus LS write 0x30=0x5A in one cycle -> both granted. Next cycle IfRvalid=1 only. LS read 0x30 afterwards -> 0x5A.
- Collision, mem[0x40]=0x11: IF read 0x40 plus LS write 0x40=0x22 in the same cycle -> IfRdata=0x11 without the macro, 0x22 with RAM_WRITE_BYPASS_EN.
- Mid-operation reset: LS read granted, nreset pulsed low before the next edge -> LsRvalid stays 0, starve_cnt=0.
- Randomized back-to-back traffic checked against a reference memory model -> IfRvalid and LsRvalid never both high; every granted read is answered exactly once, one cycle later.
